// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. It owns the PC and requests instruction words
// from instruction memory. Each word is handed to the IF/ID latch. If the latch
// stalls, one word is parked in a buffer and the unit stops issuing requests until
// the latch can take it.
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   nRST         synchronous, active-high reset
//   ihit/iload   memory response valid / instruction word
//   stall        IF/ID latch cannot accept this cycle
//   redirect_en  taken branch/jump; redirect_pc is the new PC (bits [1:0] ignored)
//   halt         stop fetching until reset
//   imemREN      memory read request (FETCH only)
//   imemaddr     fetch address (= pc)
//   instr_out    instruction presented to IF/ID (0 when no load strobe)
//   npc_out      pc+4 of the presented instruction (0 when no load strobe)
//   ifid_enable  IF/ID load strobe
//   flush        IF/ID clear strobe
//   fetch_count  instructions delivered since reset, wraps at 16 bits
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic        ifid_enable,
  output logic        flush,
  output logic [15:0] fetch_count
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] instr_buf;
  logic [CW-1:0] count;
  logic [AW-1:0] pc_plus4;
  logic [AW-1:0] target;
  logic          deliver_fetch;
  logic          deliver_hold;

  // pc+4 wraps naturally modulo 2^32; the target is forced word aligned
  assign pc_plus4      = pc + AW'(4);
  assign target        = redirect_pc & ~AW'(3);
  assign deliver_fetch = (state == FETCH) && ihit && !stall;
  assign deliver_hold  = (state == HOLD) && !stall;

  // State, PC, parked-instruction buffer and delivery counter
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state     <= FETCH;
      pc        <= PC_INIT;
      instr_buf <= '0;
      count     <= '0;
    end else if (halt) begin
      state <= HALTED;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_en) begin
            pc <= target;
          end else if (ihit && stall) begin
            instr_buf <= iload;
            state     <= HOLD;
          end else if (ihit) begin
            pc    <= pc_plus4;
            count <= count + CW'(1);
          end
        end
        HOLD: begin
          if (redirect_en) begin
            pc        <= target;
            instr_buf <= '0;
            state     <= FETCH;
          end else if (!stall) begin
            pc    <= pc_plus4;
            count <= count + CW'(1);
            state <= FETCH;
          end
        end
        default: ;  // HALTED: only reset leaves
      endcase
    end
  end

  // IF/ID strobes and payload respond within the cycle; halt masks everything
  always_comb begin
    ifid_enable = 1'b0;
    flush       = 1'b0;
    instr_out   = '0;
    npc_out     = '0;
    if (!nRST && !halt && (state != HALTED)) begin
      if (redirect_en) begin
        flush = 1'b1;
      end else if (deliver_fetch) begin
        ifid_enable = 1'b1;
        instr_out   = iload;
        npc_out     = pc_plus4;
      end else if (deliver_hold) begin
        ifid_enable = 1'b1;
        instr_out   = instr_buf;
        npc_out     = pc_plus4;
      end
    end
  end

  // Memory-side outputs and the counter read as zero while reset is held
  assign imemREN     = !nRST && (state == FETCH);
  assign imemaddr    = nRST ? '0 : pc;
  assign fetch_count = nRST ? '0 : count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. The stimulus thread queues every expected IF/ID strobe.
// A negedge monitor pops an entry each time dut0 strobes and compares it.
// Direct checks cover PC, request and counter values. A second instance with a
// wrapping PC_INIT covers PC and counter wrap-around.
module tb_fetch_unit;

  typedef struct {
    logic        is_flush;
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST, ihit, stall, redirect_en, halt;
  logic [31:0] iload, redirect_pc;
  logic        imemREN, ifid_enable, flush;
  logic [31:0] imemaddr, instr_out, npc_out;
  logic [15:0] fetch_count;

  logic        nRST1, ihit1;
  logic [31:0] iload1;
  logic        imemREN1, ifid_enable1, flush1;
  logic [31:0] imemaddr1, instr_out1, npc_out1;
  logic [15:0] fetch_count1;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut0 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .instr_out(instr_out),
    .npc_out(npc_out), .ifid_enable(ifid_enable), .flush(flush),
    .fetch_count(fetch_count)
  );

  fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut1 (
    .CLK(CLK), .nRST(nRST1), .ihit(ihit1), .iload(iload1), .stall(zero1),
    .redirect_en(zero1), .redirect_pc(zero32), .halt(zero1),
    .imemREN(imemREN1), .imemaddr(imemaddr1), .instr_out(instr_out1),
    .npc_out(npc_out1), .ifid_enable(ifid_enable1), .flush(flush1),
    .fetch_count(fetch_count1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of dut0 inputs just after the rising edge
  task automatic apply(input logic rst, input logic h, input logic [31:0] ld,
                       input logic st, input logic re, input logic [31:0] rp,
                       input logic hl);
    @(posedge CLK);
    #1;
    nRST = rst; ihit = h; iload = ld; stall = st;
    redirect_en = re; redirect_pc = rp; halt = hl;
  endtask

  task automatic exp_deliver(input logic [31:0] i, input logic [31:0] n);
    exp_t e;
    e.is_flush = 1'b0; e.instr = i; e.npc = n;
    q.push_back(e);
  endtask

  task automatic exp_flush();
    exp_t e;
    e.is_flush = 1'b1; e.instr = 32'h0; e.npc = 32'h0;
    q.push_back(e);
  endtask

  // Scoreboard monitor for dut0's IF/ID interface
  always @(negedge CLK) begin
    if (nRST === 1'b0 || nRST === 1'b1) begin
      total++;
      if (ifid_enable && flush) begin
        bad++;
        $display("FAIL strobes_exclusive: ifid_enable=%b flush=%b", ifid_enable, flush);
      end
      if (ifid_enable || flush) begin
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: ifid_enable=%b flush=%b instr=%h", ifid_enable, flush, instr_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (flush !== e.is_flush || ifid_enable !== !e.is_flush ||
              instr_out !== e.instr || npc_out !== e.npc) begin
            bad++;
            $display("FAIL ifid_payload: got flush=%b en=%b instr=%h npc=%h expected flush=%b instr=%h npc=%h",
                     flush, ifid_enable, instr_out, npc_out, e.is_flush, e.instr, e.npc);
          end
        end
      end else if (instr_out !== 32'h0 || npc_out !== 32'h0) begin
        bad++;
        $display("FAIL idle_payload: got instr=%h npc=%h expected 0", instr_out, npc_out);
      end
    end
  end

  initial begin
    nRST = 1'b1; ihit = 1'b0; iload = 32'h0; stall = 1'b0;
    redirect_en = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    nRST1 = 1'b1; ihit1 = 1'b0; iload1 = 32'h0;

    // Reset held with ihit asserted: everything reads zero
    apply(1, 1, 32'h1234_5678, 0, 0, 32'h0, 0);
    apply(1, 1, 32'h1234_5678, 0, 0, 32'h0, 0);
    @(negedge CLK);
    chk("rst_imemREN", 32'(imemREN), 32'h0);
    chk("rst_imemaddr", imemaddr, 32'h0);
    chk("rst_count", 32'(fetch_count), 32'h0);

    // Straight-line fetch at 0 and 4
    for (int k = 0; k < 2; k++) begin
      apply(0, 1, 32'h1000_0000 + 32'(k), 0, 0, 32'h0, 0);
      exp_deliver(32'h1000_0000 + 32'(k), 32'(4 * k + 4));
      @(negedge CLK);
      chk("line_imemaddr", imemaddr, 32'(4 * k));
      chk("line_imemREN", 32'(imemREN), 32'h1);
      chk("line_count", 32'(fetch_count), 32'(k));
    end

    // Capture DEADBEEF at pc=8, then three stalled HOLD cycles
    apply(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 0);
    @(negedge CLK);
    chk("cap_imemaddr", imemaddr, 32'h8);
    chk("cap_imemREN", 32'(imemREN), 32'h1);
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 32'h5555_0000 + 32'(k), 1, 0, 32'h0, 0);
      @(negedge CLK);
      chk("hold_imemREN", 32'(imemREN), 32'h0);
    end
    apply(0, 1, 32'h6666_6666, 0, 0, 32'h0, 0);
    exp_deliver(32'hDEAD_BEEF, 32'd12);
    @(negedge CLK);
    chk("release_count", 32'(fetch_count), 32'h2);

    // No response: nothing moves, stall irrelevant
    apply(0, 0, 32'h0, 0, 0, 32'h0, 0);
    @(negedge CLK);
    chk("after_hold_imemaddr", imemaddr, 32'd12);
    chk("after_hold_imemREN", 32'(imemREN), 32'h1);
    chk("after_hold_count", 32'(fetch_count), 32'h3);
    apply(0, 0, 32'h0, 1, 0, 32'h0, 0);
    @(negedge CLK);
    chk("nohit_imemaddr", imemaddr, 32'd12);

    // Redirect wins over ihit; low target bits dropped
    apply(0, 1, 32'h7777_7777, 0, 1, 32'h0000_0103, 0);
    exp_flush();
    apply(0, 1, 32'h0000_000A, 0, 0, 32'h0, 0);
    exp_deliver(32'h0000_000A, 32'h104);
    @(negedge CLK);
    chk("redir_imemaddr", imemaddr, 32'h100);
    chk("redir_count", 32'(fetch_count), 32'h3);

    // Redirect while holding a parked word: buffer dropped
    apply(0, 1, 32'h0000_BBBB, 1, 0, 32'h0, 0);
    apply(0, 0, 32'h0, 1, 1, 32'h0000_0200, 0);
    exp_flush();
    apply(0, 1, 32'h0000_000C, 0, 0, 32'h0, 0);
    exp_deliver(32'h0000_000C, 32'h204);
    @(negedge CLK);
    chk("hold_redir_imemaddr", imemaddr, 32'h200);
    chk("hold_redir_imemREN", 32'(imemREN), 32'h1);
    chk("hold_redir_count", 32'(fetch_count), 32'h4);

    // Reset during HOLD resumes at PC_INIT
    apply(0, 1, 32'h0000_EEEE, 1, 0, 32'h0, 0);
    apply(1, 0, 32'h0, 1, 0, 32'h0, 0);
    @(negedge CLK);
    chk("rst_hold_imemaddr", imemaddr, 32'h0);
    apply(0, 0, 32'h0, 0, 0, 32'h0, 0);
    @(negedge CLK);
    chk("post_rst_imemREN", 32'(imemREN), 32'h1);
    chk("post_rst_imemaddr", imemaddr, 32'h0);
    chk("post_rst_count", 32'(fetch_count), 32'h0);

    // Deliver once, then halt together with redirect
    apply(0, 1, 32'h0000_0F0F, 0, 0, 32'h0, 0);
    exp_deliver(32'h0000_0F0F, 32'h4);
    apply(0, 1, 32'h1111_1111, 0, 1, 32'h0000_0400, 1);
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 32'h2222_2222, 0, 1, 32'h0000_0800, 0);
      @(negedge CLK);
      chk("halted_imemREN", 32'(imemREN), 32'h0);
      chk("halted_imemaddr", imemaddr, 32'h4);
    end
    apply(1, 0, 32'h0, 0, 0, 32'h0, 0);
    apply(0, 0, 32'h0, 0, 0, 32'h0, 0);
    @(negedge CLK);
    chk("unhalt_imemaddr", imemaddr, 32'h0);
    chk("unhalt_imemREN", 32'(imemREN), 32'h1);
    chk("queue_drained", 32'(q.size()), 32'h0);

    // Wrap instance: PC and counter roll over
    @(posedge CLK);
    #1;
    nRST1 = 1'b1; ihit1 = 1'b1; iload1 = 32'h0BAD_F00D;
    @(posedge CLK);
    #1;
    nRST1 = 1'b0;
    for (int i = 0; i <= 65536; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        chk("wrap_imemaddr0", imemaddr1, 32'hFFFF_FFFC);
        chk("wrap_npc", npc_out1, 32'h0);
        chk("wrap_instr", instr_out1, 32'h0BAD_F00D);
        chk("wrap_en", 32'(ifid_enable1), 32'h1);
      end else if (i == 1) begin
        chk("wrap_imemaddr1", imemaddr1, 32'h0);
        chk("wrap_count1", 32'(fetch_count1), 32'h1);
      end else if (i == 65535) begin
        chk("count_ffff", 32'(fetch_count1), 32'hFFFF);
      end else if (i == 65536) begin
        chk("count_wrap", 32'(fetch_count1), 32'h0);
        chk("wrap_flush", 32'(flush1), 32'h0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000, PC value loaded on reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset; synchronous, active-high (1 = reset asserted), sampled on rising CLK.
REQ-004 ihit  input  1  instruction memory response valid for the current request this cycle.
REQ-005 iload  input  32  instruction word from memory, valid when ihit=1.
REQ-006 stall  input  1  downstream IF/ID latch cannot accept this cycle (hazard).
REQ-007 redirect_en  input  1  branch/jump taken; redirect_pc replaces PC.
REQ-008 redirect_pc  input  32  redirect target; bits [1:0] are ignored and forced to 0.
REQ-009 halt  input  1  stop fetching permanently until reset.
REQ-010 imemREN  output  1  instruction memory read request.
REQ-011 imemaddr  output  32  fetch address; equals pc.
REQ-012 instr_out  output  32  instruction presented to IF/ID latch.
REQ-013 npc_out  output  32  pc+4 of the presented instruction.
REQ-014 ifid_enable  output  1  IF/ID latch load strobe.
REQ-015 flush  output  1  IF/ID latch clear strobe.
REQ-016 fetch_count  output  16  instructions delivered since reset; wraps 16'hFFFF -> 0.

Function
REQ-017 The unit SHALL hold a 3-state FSM: FETCH, HOLD, HALTED, plus registers pc[31:0], buf[31:0] and fetch_count.
REQ-018 In FETCH the unit SHALL drive imemREN=1 and imemaddr=pc.
REQ-019 In HOLD and HALTED the unit SHALL drive imemREN=0.
REQ-020 Per-cycle priority SHALL be: nRST > halt > redirect_en > delivery > capture.
REQ-021 If halt=1 in any state, the unit SHALL go to HALTED next cycle with ifid_enable=0 and flush=0 that cycle, and pc SHALL be unchanged.
REQ-022 If redirect_en=1 (no halt) in FETCH or HOLD, the unit SHALL assert flush=1 and ifid_enable=0 combinationally, load pc<={redirect_pc[31:2],2'b00}, discard any ihit data or buf, and go to FETCH.
REQ-023 Delivery: in FETCH with ihit=1, stall=0 and no redirect, the unit SHALL assert ifid_enable=1 with instr_out=iload, npc_out=pc+4, then pc<=pc+4 and fetch_count+1, staying in FETCH.
REQ-024 Capture: in FETCH with ihit=1, stall=1 and no redirect, the unit SHALL load buf<=iload, hold ifid_enable=0, keep pc, and go to HOLD.
REQ-025 In HOLD with stall=0 and no redirect, the unit SHALL assert ifid_enable=1 with instr_out=buf, npc_out=pc+4, then pc<=pc+4 and fetch_count+1, and return to FETCH.
REQ-026 In HOLD with stall=1, the unit SHALL keep buf, pc and state and assert neither strobe.
REQ-027 In FETCH with ihit=0, the unit SHALL keep pc and state and assert neither strobe; stall is irrelevant.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-029 ifid_enable and flush SHALL never both be 1 in the same cycle.
REQ-030 When neither strobe is asserted, instr_out and npc_out SHALL be 0.
REQ-031 HALTED SHALL be exited only by reset; redirect_en, ihit and stall SHALL be ignored there.

Reset
REQ-032 While nRST=1, all outputs SHALL be 0 (imemREN, ifid_enable, flush, instr_out, npc_out, fetch_count, imemaddr).
REQ-033 On a clock edge with nRST=1, state SHALL become FETCH, pc PC_INIT, buf 0 and fetch_count 0.
REQ-034 Reset asserted mid-HOLD or in HALTED SHALL discard buf and resume in FETCH at PC_INIT on the first cycle with nRST=0.

Verification
REQ-035 Straight-line: PC_INIT=0, ihit=1 every cycle, stall=0 -> imemaddr 0,4,8,...; npc_out 4,8,12,...; fetch_count increments each cycle.
REQ-036 Stall capture: ihit=1 with iload=32'hDEAD_BEEF at pc=8, stall=1 for 3 cycles -> imemREN=0 for 3 cycles, then ifid_enable=1, instr_out=DEADBEEF, npc_out=12, next imemaddr=12.
REQ-037 Redirect over ihit: in FETCH with ihit=1, redirect_en=1, redirect_pc=32'h0000_0103 -> flush=1, ifid_enable=0, next imemaddr=32'h100, fetch_count unchanged.
REQ-038 Redirect in HOLD: buf holds an instruction, redirect_en=1 with stall=1 -> flush=1, buf discarded, FETCH at target next cycle.
REQ-039 Halt vs redirect: halt=1 and redirect_en=1 in the same cycle -> HALTED, pc unchanged, imemREN=0 thereafter despite ihit/redirect; reset -> imemaddr=PC_INIT.
REQ-040 Wrap: PC_INIT=32'hFFFF_FFFC, ihit=1 -> npc_out=0, next imemaddr=0; fetch_count forced through 16'hFFFF -> 0.
